// File: rtl/ser2par_rx_pkg.sv
// ser2par_rx_pkg: shared types for the serial-to-parallel receiver
package ser2par_rx_pkg;
   typedef enum logic {DIR_LSB = 1'b0, DIR_MSB = 1'b1} dir_e;
endpackage

// File: rtl/ser2par_rx_if.sv
// ser2par_rx_if: serial link input side and parallel valid/ready output side
interface ser2par_rx_if #(parameter int DW = 4);
   logic          sdata;
   logic          svalid;
   logic          msb_first;
   logic          flush;
   logic [DW-1:0] pdata;
   logic          pvalid;
   logic          pready;
   logic          busy;
   logic          overrun;
   logic          clr_ovr;
   modport master (
      output sdata, svalid, msb_first, flush, pready, clr_ovr,
      input  pdata, pvalid, busy, overrun
   );
   modport slave (
      input  sdata, svalid, msb_first, flush, pready, clr_ovr,
      output pdata, pvalid, busy, overrun
   );
endinterface

// File: rtl/ser2par_outbuf.sv
// ser2par_outbuf: single-entry valid/ready holding register with sticky overrun
module ser2par_outbuf #(parameter int DW = 4) (
   input  logic          clk,
   input  logic          async_rst,
   input  logic          done,
   input  logic [DW-1:0] word,
   input  logic          pready,
   input  logic          clr_ovr,
   output logic [DW-1:0] pdata,
   output logic          pvalid,
   output logic          overrun
);
   logic drop;
   assign drop = done && pvalid && !pready;
   // load a completed word when the slot is empty or draining; otherwise flag the loss
   always_ff @(posedge clk or posedge async_rst)
      if (async_rst) begin
         pdata   <= '0;
         pvalid  <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if (done && (!pvalid || pready)) begin
            pdata  <= word;
            pvalid <= 1'b1;
         end else if (pvalid && pready)
            pvalid <= 1'b0;
         overrun <= drop || (overrun && !clr_ovr);
      end
endmodule

// File: rtl/ser2par_rx.sv
// ser2par_rx: collects DW serial bits (LSB- or MSB-first) into words on a valid/ready port
module ser2par_rx import ser2par_rx_pkg::*; #(parameter int DW = 4) (
   input logic        clk,
   input logic        async_rst,
   ser2par_rx_if.slave bus
);
   localparam int CW = $clog2(DW + 1);
   logic [DW-1:0] sh, sh_nxt;
   logic [CW-1:0] cnt;
   dir_e          dir_q, dir_cur;
   logic          acc, done;
   // first bit of a word takes the live direction; later bits use the latched one
   always_comb begin
      acc     = bus.svalid && !bus.flush;
      dir_cur = (cnt == '0) ? dir_e'(bus.msb_first) : dir_q;
      sh_nxt  = (dir_cur == DIR_MSB) ? {sh[DW-2:0], bus.sdata} : {bus.sdata, sh[DW-1:1]};
      done    = acc && (cnt == CW'(DW - 1));
   end
   // shift register, bit count and direction latch; flush drops the partial word
   always_ff @(posedge clk or posedge async_rst)
      if (async_rst) begin
         sh    <= '0;
         cnt   <= '0;
         dir_q <= DIR_LSB;
      end else if (bus.flush) begin
         sh  <= '0;
         cnt <= '0;
      end else if (acc) begin
         sh    <= sh_nxt;
         cnt   <= done ? '0 : cnt + CW'(1);
         dir_q <= dir_cur;
      end
   assign bus.busy = (cnt != '0);
   ser2par_outbuf #(.DW(DW)) u_outbuf (
      .clk      (clk),
      .async_rst(async_rst),
      .done     (done),
      .word     (sh_nxt),
      .pready   (bus.pready),
      .clr_ovr  (bus.clr_ovr),
      .pdata    (bus.pdata),
      .pvalid   (bus.pvalid),
      .overrun  (bus.overrun)
   );
endmodule
